// File: rtl/tl_pkg.sv
// Shared types for the traffic-light phase controller family.
// State encodings, lamp encoding and the per-phase lamp decode.
package tl_pkg;

  localparam int PH_W = 3;

  typedef enum logic [2:0] {
    ST_GREEN  = 3'b000,
    ST_YELLOW = 3'b001,
    ST_ALLRED = 3'b010,
    ST_FLASH  = 3'b011,
    ST_START  = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    LAMP_RED    = 2'd0,
    LAMP_YELLOW = 2'd1,
    LAMP_GREEN  = 2'd2,
    LAMP_OFF    = 2'd3
  } lamp_t;

  // own: this phase holds the right of way; lit: flash half-cycle
  function automatic lamp_t lamp_of(
    input state_t s,
    input logic   own,
    input logic   lit
  );
    lamp_t l;
    l = LAMP_RED;
    unique case (1'b1)
      (s == ST_GREEN) && own:  l = LAMP_GREEN;
      (s == ST_YELLOW) && own: l = LAMP_YELLOW;
      (s == ST_FLASH) && !lit: l = LAMP_OFF;
      default:                 l = LAMP_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_ctrl_if.sv
// Prescaler/demand inputs and lamp outputs of tl_phase_ctrl.
// i_flash exists only when TL_FLASH_EN is defined.
interface tl_phase_ctrl_if #(
  parameter int N_PHASES = 2
);
  logic                i_tick;
  logic [N_PHASES-1:0] i_req;
  logic [N_PHASES-1:0] o_red;
  logic [N_PHASES-1:0] o_yellow;
  logic [N_PHASES-1:0] o_green;
  logic [2:0]          o_phase;
  logic [2:0]          o_state;
  logic [N_PHASES-1:0] o_demand;
`ifdef TL_FLASH_EN
  logic                i_flash;

  modport master (
    output i_tick, i_req, i_flash,
    input  o_red, o_yellow, o_green,
    input  o_phase, o_state, o_demand
  );

  modport slave (
    input  i_tick, i_req, i_flash,
    output o_red, o_yellow, o_green,
    output o_phase, o_state, o_demand
  );
`else
  modport master (
    output i_tick, i_req,
    input  o_red, o_yellow, o_green,
    input  o_phase, o_state, o_demand
  );

  modport slave (
    input  i_tick, i_req,
    output o_red, o_yellow, o_green,
    output o_phase, o_state, o_demand
  );
`endif
endinterface

// File: rtl/tl_dwell_timer.sv
// Tick-enabled dwell down-counter with load and zero flag.
// Holds at zero so a resting state keeps its expiry pending.
module tl_dwell_timer #(
  parameter int           W       = 12,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tl_phase_ctrl.sv
// Demand-actuated round-robin traffic light controller.
// Optional flashing-red mode is enabled by defining TL_FLASH_EN.
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter int N_PHASES    = 2,
  parameter int T_WIDTH     = 12,
  parameter int START_TIME  = 20,
  parameter int GREEN_MIN   = 90,
  parameter int YELLOW_TIME = 30,
  parameter int ALLRED_TIME = 10
) (
  input logic           i_clk,
  input logic           i_rst_n,
  tl_phase_ctrl_if.slave bus
);

  localparam logic [T_WIDTH-1:0] LD_START  = T_WIDTH'(START_TIME - 1);
  localparam logic [T_WIDTH-1:0] LD_GREEN  = T_WIDTH'(GREEN_MIN - 1);
  localparam logic [T_WIDTH-1:0] LD_YELLOW = T_WIDTH'(YELLOW_TIME - 1);
  localparam logic [T_WIDTH-1:0] LD_ALLRED = T_WIDTH'(ALLRED_TIME - 1);
  localparam logic [N_PHASES-1:0] ONE = N_PHASES'(1);

  state_t              state;
  logic [PH_W-1:0]     phase;
  logic [PH_W-1:0]     prev;
  logic [N_PHASES-1:0] demand;
  logic [N_PHASES-1:0] own;
  logic [N_PHASES-1:0] req_eff;
  logic [N_PHASES-1:0] red;
  logic [N_PHASES-1:0] yellow;
  logic [N_PHASES-1:0] green;
  logic [T_WIDTH-1:0]  load_val;
  logic [T_WIDTH-1:0]  count;
  logic                zero;
  logic                load;
  logic                expire;
  logic                other;
  logic                flash;
  logic                lit;

`ifdef TL_FLASH_EN
  assign flash = bus.i_flash;
`else
  assign flash = 1'b0;
`endif

  // First phase after p (wrapping, p itself last) with demand
  function automatic logic [PH_W-1:0] pick(
    input logic [PH_W-1:0]     p,
    input logic [N_PHASES-1:0] d
  );
    logic [PH_W-1:0] r;
    int k;
    k = (int'(p) + 1) % N_PHASES;
    r = PH_W'(k);
    for (int i = N_PHASES; i >= 1; i--) begin
      k = (int'(p) + i) % N_PHASES;
      if (d[k]) r = PH_W'(k);
    end
    return r;
  endfunction

  assign own     = ONE << phase;
  assign req_eff = (state == ST_GREEN) ? (bus.i_req & ~own) : bus.i_req;
  assign expire  = bus.i_tick & zero;
  assign other   = |(demand & ~own);

  always_comb begin
    load     = 1'b0;
    load_val = LD_GREEN;
    unique case (1'b1)
      state == ST_START: begin
        load     = expire;
        load_val = LD_GREEN;
      end
      state == ST_GREEN: begin
        load     = flash | (expire & other);
        load_val = LD_YELLOW;
      end
      state == ST_YELLOW: begin
        load     = expire;
        load_val = LD_ALLRED;
      end
      state == ST_ALLRED: begin
        load     = expire;
        load_val = LD_GREEN;
      end
      state == ST_FLASH: begin
        load     = ~flash;
        load_val = LD_START;
      end
      default: ;
    endcase
  end

  tl_dwell_timer #(
    .W       (T_WIDTH),
    .RST_VAL (LD_START)
  ) u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .tick     (bus.i_tick),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .zero     (zero)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= ST_START;
      phase  <= '0;
      prev   <= '0;
      demand <= '0;
      lit    <= 1'b1;
    end else begin
      demand <= demand | req_eff;
      case (state)
        ST_START: begin
          if (expire) begin
            state  <= ST_GREEN;
            phase  <= '0;
            demand <= (demand | req_eff) & ~ONE;
`ifdef TL_FLASH_EN
            if (flash) begin
              state  <= ST_FLASH;
              lit    <= 1'b1;
              demand <= demand | req_eff;
            end
`endif
          end
        end
        ST_GREEN: begin
          if (load) state <= ST_YELLOW;
        end
        ST_YELLOW: begin
          if (expire) begin
            state <= ST_ALLRED;
            prev  <= phase;
            phase <= pick(phase, demand);
          end
        end
        ST_ALLRED: begin
          phase <= pick(prev, demand);
          if (expire) begin
            state  <= ST_GREEN;
            demand <= (demand | req_eff) & ~(ONE << pick(prev, demand));
`ifdef TL_FLASH_EN
            if (flash) begin
              state  <= ST_FLASH;
              lit    <= 1'b1;
              demand <= demand | req_eff;
            end
`endif
          end
        end
`ifdef TL_FLASH_EN
        ST_FLASH: begin
          if (!flash) begin
            state  <= ST_START;
            phase  <= '0;
            demand <= '0;
          end else if (bus.i_tick) begin
            lit <= ~lit;
          end
        end
`endif
        default: state <= ST_START;
      endcase
    end
  end

  always_comb begin
    red    = '0;
    yellow = '0;
    green  = '0;
    for (int k = 0; k < N_PHASES; k++) begin
      case (lamp_of(state, phase == PH_W'(k), lit))
        LAMP_RED:    red[k]    = 1'b1;
        LAMP_YELLOW: yellow[k] = 1'b1;
        LAMP_GREEN:  green[k]  = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.o_red    = red;
  assign bus.o_yellow = yellow;
  assign bus.o_green  = green;
  assign bus.o_phase  = phase;
  assign bus.o_state  = state;
  assign bus.o_demand = demand;

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// Scoreboard bench for tl_phase_ctrl: tick-level reference model
// predicts lamps, phase, state and demand for every clock.
module tb_tl_phase_ctrl;
  import tl_pkg::*;

  localparam int N  = 3;
  localparam int TS = 20;
  localparam int TG = 90;
  localparam int TY = 30;
  localparam int TA = 10;
  localparam int NCYC = 24000;

  typedef struct packed {
    logic [2:0]   st;
    logic [2:0]   ph;
    logic [N-1:0] r;
    logic [N-1:0] y;
    logic [N-1:0] g;
    logic [N-1:0] d;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  snap_t q[$];

  always #5 clk = ~clk;

  tl_phase_ctrl_if #(.N_PHASES(N)) bus();

  tl_phase_ctrl #(
    .N_PHASES    (N),
    .T_WIDTH     (12),
    .START_TIME  (TS),
    .GREEN_MIN   (TG),
    .YELLOW_TIME (TY),
    .ALLRED_TIME (TA)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Reference: remaining ticks in the interval, demand bits, owner
  state_t       m_st;
  int           m_ph;
  int           m_prev;
  int           m_left;
  logic [N-1:0] m_dem;

  function automatic int next_served(input int p, input logic [N-1:0] d);
    for (int i = 1; i <= N; i++) begin
      if (d[(p + i) % N]) return (p + i) % N;
    end
    return (p + 1) % N;
  endfunction

  task automatic model_step(input logic r, input logic t,
                            input logic [N-1:0] rq);
    logic [N-1:0] nd;
    bit ex;
    bit oth;
    if (!r) begin
      m_st = ST_START; m_ph = 0; m_prev = 0;
      m_left = TS; m_dem = '0;
      return;
    end
    nd = m_dem;
    for (int k = 0; k < N; k++)
      if (rq[k] && !(m_st == ST_GREEN && k == m_ph)) nd[k] = 1'b1;
    oth = 1'b0;
    for (int k = 0; k < N; k++)
      if (k != m_ph && m_dem[k]) oth = 1'b1;
    ex = t && (m_left == 1);
    if (t && m_left > 1) m_left--;
    case (m_st)
      ST_START: if (ex) begin
        m_st = ST_GREEN; m_ph = 0; m_left = TG; nd[0] = 1'b0;
      end
      ST_GREEN: if (ex && oth) begin
        m_st = ST_YELLOW; m_left = TY;
      end
      ST_YELLOW: if (ex) begin
        m_st = ST_ALLRED; m_left = TA;
        m_prev = m_ph; m_ph = next_served(m_prev, m_dem);
      end
      ST_ALLRED: begin
        m_ph = next_served(m_prev, m_dem);
        if (ex) begin
          m_st = ST_GREEN; m_left = TG; nd[m_ph] = 1'b0;
        end
      end
      default: ;
    endcase
    m_dem = nd;
  endtask

  function automatic snap_t expect_now();
    snap_t e;
    e.st = m_st;
    e.ph = 3'(m_ph);
    e.r  = '1;
    e.y  = '0;
    e.g  = '0;
    e.d  = m_dem;
    if (m_st == ST_GREEN) begin
      e.r[m_ph] = 1'b0; e.g[m_ph] = 1'b1;
    end else if (m_st == ST_YELLOW) begin
      e.r[m_ph] = 1'b0; e.y[m_ph] = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      snap_t e;
      snap_t a;
      e = q.pop_front();
      a = {bus.o_state, bus.o_phase, bus.o_red,
           bus.o_yellow, bus.o_green, bus.o_demand};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL lamps cyc=%0d got st=%b ph=%0d r=%b y=%b g=%b d=%b exp st=%b ph=%0d r=%b y=%b g=%b d=%b",
                 cyc, a.st, a.ph, a.r, a.y, a.g, a.d,
                 e.st, e.ph, e.r, e.y, e.g, e.d);
      end
    end
  end

`ifdef TL_FLASH_EN
  initial bus.i_flash = 1'b0;
`endif

  initial begin
    logic [N-1:0] hold;
    int yrst;
    hold = '0;
    yrst = 0;
    rst_n = 1'b0;
    bus.i_tick = 1'b0;
    bus.i_req = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      model_step(rst_n, bus.i_tick, bus.i_req);
      q.push_back(expect_now());
      rst_n = (c >= 2);
      if (c < 2200) begin
        bus.i_tick = (c % 4 == 0);
        bus.i_req  = '0;
      end else begin
        bus.i_tick = ($urandom_range(0, 2) == 0);
        for (int k = 0; k < N; k++) begin
          if ($urandom_range(0, 299) == 0) hold[k] = ~hold[k];
          bus.i_req[k] = hold[k] | ($urandom_range(0, 149) == 0);
        end
        if (yrst < 3 && m_st == ST_YELLOW && m_left < TY - 3
            && $urandom_range(0, 9) == 0) begin
          rst_n = 1'b0;
          yrst++;
        end
        if ($urandom_range(0, 7999) == 0) rst_n = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
